clk_rx_mon: RTL and testbench

CLK_RX_MON -- requirements
Module: clk_rx_mon

---
 rtl/clk_rx_mon_pkg.sv | 14 +
 rtl/clk_rx_mon_edge_sync.sv | 45 ++++
 rtl/clk_rx_mon.sv | 91 +++++++++
 tb/tb_clk_rx_mon.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rx_mon_pkg.sv
// Shared types and defaults for the slow-clock receive monitor.
package clk_rx_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_LOCKED = 2'd2,
      ST_LOST   = 2'd3
   } state_e;

   localparam int DEF_PERIOD_W = 8;
   localparam int DEF_TIMEOUT  = 64;

endpackage

// File: rtl/clk_rx_mon_edge_sync.sv
// Synchronizes an asynchronous level into clk and emits registered rise/fall strobes.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din_i,
   output logic rise_o,
   output logic fall_o
);

   logic       meta_q;
   logic       sync_q;
   logic       prev_q;
   logic [2:0] vld_q;
   logic       rise_q;
   logic       fall_q;
   logic       rise_d;
   logic       fall_d;

   // prev_q only holds a real sample once vld_q[2] is set; before that the
   // reset-low pipeline would fake a rise for a level that was already high.
   assign rise_d = vld_q[2] & sync_q & ~prev_q;
   assign fall_d = vld_q[2] & ~sync_q & prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         vld_q  <= 3'b000;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         meta_q <= din_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         vld_q  <= {vld_q[1:0], 1'b1};
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/clk_rx_mon.sv
// Slow-clock monitor: edge strobes, rise-to-rise period measurement and loss detection.
//   state     | meaning
//   ST_IDLE   | out of reset, no rise seen yet
//   ST_ARMED  | one rise seen, period not yet measured
//   ST_LOCKED | period holds a real rise-to-rise measurement
//   ST_LOST   | no edge for TIMEOUT cycles
module clk_rx_mon
   import clk_rx_mon_pkg::*;
#(
   parameter int PERIOD_W = DEF_PERIOD_W,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                slowclk,
   output logic                tick_rise,
   output logic                tick_fall,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                lost
);

   localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
   localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);
   localparam logic [PERIOD_W-1:0] TO_CNT  = PERIOD_W'(TIMEOUT);

   state_e              state_q, state_d;
   logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
   logic [PERIOD_W-1:0] icnt_q, icnt_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                pv_q;
   logic                lost_q;
   logic                rise_ev;
   logic                fall_ev;

   edge_sync u_edge_sync (
      .clk    (clk),
      .rst    (rst),
      .din_i  (slowclk),
      .rise_o (rise_ev),
      .fall_o (fall_ev)
   );

   // A rise clears icnt, so it can never coincide with the timeout transition.
   always_comb begin
      pcnt_d   = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_ONE;
      icnt_d   = (icnt_q == TO_CNT)  ? icnt_q : icnt_q + CNT_ONE;
      period_d = period_q;
      state_d  = state_q;
      if (rise_ev || fall_ev) begin
         icnt_d = '0;
      end
      if (rise_ev) begin
         pcnt_d = CNT_ONE;
         case (state_q)
            ST_ARMED, ST_LOCKED: begin
               state_d  = ST_LOCKED;
               period_d = pcnt_q;
            end
            default: state_d = ST_ARMED;
         endcase
      end else if (icnt_d == TO_CNT && state_q != ST_LOST) begin
         state_d = ST_LOST;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pcnt_q   <= '0;
         icnt_q   <= '0;
         period_q <= '0;
         pv_q     <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pcnt_q   <= pcnt_d;
         icnt_q   <= icnt_d;
         period_q <= period_d;
         pv_q     <= (state_d == ST_LOCKED);
         lost_q   <= (state_d == ST_LOST);
      end
   end

   assign tick_rise    = rise_ev;
   assign tick_fall    = fall_ev;
   assign period       = period_q;
   assign period_valid = pv_q;
   assign lost         = lost_q;

endmodule

// File: tb/tb_clk_rx_mon.sv
// Scoreboard bench for clk_rx_mon: stimulus predicts strobe/loss events, a monitor matches them.
module tb_clk_rx_mon;

   localparam int PW   = 6;
   localparam int TO   = 40;
   localparam int PMAX = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          slowclk = 1'b0;
   logic          tick_rise;
   logic          tick_fall;
   logic [PW-1:0] period;
   logic          period_valid;
   logic          lost;

   clk_rx_mon #(.PERIOD_W(PW), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .slowclk      (slowclk),
      .tick_rise    (tick_rise),
      .tick_fall    (tick_fall),
      .period       (period),
      .period_valid (period_valid),
      .lost         (lost)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      int edge_n;
      bit rise;
      bit fall;
      bit lost_rise;
      int per;
      bit pv;
      bit lst;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: samples taken at each clk edge since reset (-1 = not yet known).
   typedef enum int {M_IDLE, M_ARMED, M_LOCKED, M_LOST} mstate_t;
   int      hist[$];
   mstate_t m_state;
   int      m_pcnt, m_icnt, m_period;

   function automatic void m_reset();
      hist     = '{-1, -1, -1, -1};
      m_state  = M_IDLE;
      m_pcnt   = 0;
      m_icnt   = 0;
      m_period = 0;
   endfunction

   function automatic bit is_rise(input int now_v, input int old_v);
      return (now_v == 1) && (old_v == 0);
   endfunction

   function automatic bit is_fall(input int now_v, input int old_v);
      return (now_v == 0) && (old_v == 1);
   endfunction

   // Advance the model by one clk edge n that samples slowclk = v.
   function automatic void m_step(input bit v, input int n);
      int      nn;
      bit      ev_r, ev_f, tr, tf;
      mstate_t prev_st;
      exp_t    e;
      hist.push_back(int'(v));
      nn   = hist.size() - 1;
      ev_r = is_rise(hist[nn-3], hist[nn-4]);
      ev_f = is_fall(hist[nn-3], hist[nn-4]);
      prev_st = m_state;
      if (ev_r) begin
         if (m_state == M_ARMED || m_state == M_LOCKED) begin
            m_period = m_pcnt;
            m_state  = M_LOCKED;
         end else begin
            m_state = M_ARMED;
         end
         m_pcnt = 1;
         m_icnt = 0;
      end else begin
         m_pcnt = (m_pcnt < PMAX) ? m_pcnt + 1 : PMAX;
         m_icnt = ev_f ? 0 : ((m_icnt < TO) ? m_icnt + 1 : TO);
         if (m_icnt == TO && m_state != M_LOST) m_state = M_LOST;
      end
      tr = is_rise(hist[nn-2], hist[nn-3]);
      tf = is_fall(hist[nn-2], hist[nn-3]);
      if (tr || tf || (m_state == M_LOST && prev_st != M_LOST)) begin
         e.edge_n    = n;
         e.rise      = tr;
         e.fall      = tf;
         e.lost_rise = (m_state == M_LOST && prev_st != M_LOST);
         e.per       = m_period;
         e.pv        = (m_state == M_LOCKED);
         e.lst       = (m_state == M_LOST);
         q.push_back(e);
      end
      if (hist.size() > 8) void'(hist.pop_front());
   endfunction

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic drive(input bit v, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         slowclk = v;
         m_step(v, edge_cnt + 1);
      end
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL %s: %0d expected events never shown, first at edge %0d", name, q.size(), q[0].edge_n);
      end
   endtask

   task automatic do_reset(input bit level, input int cycles);
      @(negedge clk);
      check_drained("pre_reset_pending");
      rst     = 1'b1;
      slowclk = level;
      q.delete();
      m_reset();
      #1;
      chk("rst_tick_rise", int'(tick_rise), 0);
      chk("rst_tick_fall", int'(tick_fall), 0);
      chk("rst_period", int'(period), 0);
      chk("rst_period_valid", int'(period_valid), 0);
      chk("rst_lost", int'(lost), 0);
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
      m_step(slowclk, edge_cnt + 1);
   endtask

   // Monitor: match every strobe or lost assertion against the predicted queue.
   initial begin
      exp_t e;
      bit   lost_prev;
      bit   lrise;
      lost_prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            while (q.size() > 0 && q[0].edge_n < edge_cnt) begin
               checks++;
               failures++;
               $display("FAIL missing_event: edge %0d expected rise=%0d fall=%0d lost_rise=%0d, got nothing",
                        q[0].edge_n, q[0].rise, q[0].fall, q[0].lost_rise);
               void'(q.pop_front());
            end
            lrise = lost && !lost_prev;
            if (tick_rise || tick_fall || lrise) begin
               if (q.size() == 0 || q[0].edge_n != edge_cnt) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_event: edge %0d got rise=%0d fall=%0d lost_rise=%0d, expected none",
                           edge_cnt, tick_rise, tick_fall, lrise);
               end else begin
                  e = q.pop_front();
                  chk("ev_tick_rise", int'(tick_rise), int'(e.rise));
                  chk("ev_tick_fall", int'(tick_fall), int'(e.fall));
                  chk("ev_lost_rise", int'(lrise), int'(e.lost_rise));
                  chk("ev_period", int'(period), e.per);
                  chk("ev_period_valid", int'(period_valid), int'(e.pv));
                  chk("ev_lost", int'(lost), int'(e.lst));
               end
            end
         end
         lost_prev = lost;
      end
   end

   initial begin
      int sel;
      int len;
      m_reset();
      do_reset(1'b0, 2);

      // Rise first sampled at edge 10 after release.
      drive(1'b0, 8);
      drive(1'b1, 6);

      // Divide-by-6 slow clock.
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 3);
         drive(1'b1, 3);
      end
      chk("div6_period", int'(period), 6);
      chk("div6_period_valid", int'(period_valid), 1);
      chk("div6_lost", int'(lost), 0);

      // Stop the clock long enough to time out, then recover.
      drive(1'b0, TO + 8);
      chk("lost_flag", int'(lost), 1);
      chk("lost_period_valid", int'(period_valid), 0);
      chk("lost_period_kept", int'(period), 6);
      drive(1'b1, 3);
      drive(1'b0, 3);
      drive(1'b1, 3);
      drive(1'b0, 3);
      chk("relock_period", int'(period), 6);
      chk("relock_period_valid", int'(period_valid), 1);
      chk("relock_lost", int'(lost), 0);

      // Rise arriving in the cycle icnt would reach TIMEOUT.
      drive(1'b1, 3);
      drive(1'b0, TO);
      drive(1'b1, 6);
      chk("boundary_lost", int'(lost), 0);
      chk("boundary_period_valid", int'(period_valid), 1);
      chk("boundary_period", int'(period), 3 + TO);
      drive(1'b0, TO + 1);

      // Rise-to-rise of 70 cycles saturates the period.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 35);
         drive(1'b0, 35);
      end
      chk("sat_period", int'(period), PMAX);
      chk("sat_period_valid", int'(period_valid), 1);

      // Reset while locked with slowclk high: no rise until a real fall/rise.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 3);
         drive(1'b1, 3);
      end
      do_reset(1'b1, 2);
      drive(1'b1, 20);
      chk("post_rst_period_valid", int'(period_valid), 0);
      chk("post_rst_lost", int'(lost), 0);
      drive(1'b0, 3);
      drive(1'b1, 3);
      drive(1'b0, 3);

      // Randomized segments, including 1-cycle pulses, timeout-adjacent holds and resets.
      for (int seg = 0; seg < 250; seg++) begin
         sel = $urandom_range(0, 19);
         if (sel == 0) begin
            do_reset(1'($urandom_range(0, 1)), $urandom_range(1, 3));
         end else begin
            if (sel < 5)       len = $urandom_range(1, 2);
            else if (sel < 14) len = $urandom_range(2, 12);
            else if (sel < 18) len = $urandom_range(20, 63);
            else               len = $urandom_range(TO - 1, TO + 2);
            drive(~slowclk, len);
         end
      end

      drive(slowclk, 8);
      @(negedge clk);
      check_drained("final_pending");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
